// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong sample buffer (reader and writer side).
//   DATA_W    : width of a buffer word / stream byte
//   ADDR_W    : buffer address width
//   DEPTH     : words per frame (at most 2**ADDR_W)
//   rd_state_t: reader controller states
package pingpong_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    // Issue counter needs one extra bit so that DEPTH itself is representable.
    localparam int ISSUE_W = ADDR_W + 1;

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ISSUE_W-1:0] LAST_ISSUE = ISSUE_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STREAM = 2'd1,
        RD_DRAIN  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/pingpong_reader_if.sv
// Valid/ready byte stream leaving the ping-pong reader.
//   m_data  : stream byte
//   m_valid : byte valid
//   m_ready : sink accepts when m_valid & m_ready
//   m_last  : final byte of a frame
// master = the reader (source), slave = the downstream consumer.
interface pingpong_reader_if;

    logic [pingpong_pkg::DATA_W-1:0] m_data;
    logic                            m_valid;
    logic                            m_ready;
    logic                            m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/pingpong_skid2.sv
// Two-entry registered FIFO. The head entry drives the outputs directly from
// flops, so data and valid never pass through combinational logic.
//   clk, reset : clock and synchronous active-high reset
//   push_i     : write din_i this cycle
//   din_i      : entry to store
//   pop_i      : consume the head entry this cycle (ignored when empty)
//   dout_o     : head entry
//   valid_o    : FIFO not empty
//   count_o    : occupancy, 0..2
module pingpong_skid2
    import pingpong_pkg::*;
#(
    parameter int W = DATA_W + 1
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pop_s;
    logic         push_s;

    // Next-state for the two entries; a push into a full FIFO is only taken
    // when a pop frees the head in the same cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_s   = pop_i & (count_q != 2'd0);
        push_s  = push_i & ((count_q != 2'd2) | pop_s);
        case ({push_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = din_i;
                end else begin
                    tail_d = din_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end else begin
                    head_d = head_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = din_i;
                end else begin
                    head_d = din_i;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout_o  = head_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/pingpong_reader.sv
// Read-side controller for the ping-pong sample buffer. After a good_to_go
// pulse it sweeps addresses 0..DEPTH-1 through the one-cycle-latency RAM read
// port and streams the words out as valid/ready bytes, tagging the last one.
//   clk, reset : clock and synchronous active-high reset
//   good_to_go : one-cycle pulse, a fresh bank is mapped to the read port
//   r_addr     : buffer read address
//   r_q        : buffer read data, valid the cycle after r_addr
//   read_done  : high while idle (buffer may swap banks)
//   overrun    : sticky, good_to_go seen while a frame was in progress
//   m_if       : outgoing byte stream (master side)
module pingpong_reader
    import pingpong_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                good_to_go,
    output logic [ADDR_W-1:0]   r_addr,
    input  logic [DATA_W-1:0]   r_q,
    output logic                read_done,
    output logic                overrun,
    pingpong_reader_if.master   m_if
);

    rd_state_t            state_q, state_d;
    logic [ADDR_W-1:0]    r_addr_q, r_addr_d;
    logic [ISSUE_W-1:0]   issued_q, issued_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_last_q, inflight_last_d;
    logic                 read_done_q, read_done_d;
    logic                 overrun_q, overrun_d;

    logic [1:0]           fifo_count_s;
    logic                 fifo_valid_s;
    logic [DATA_W:0]      fifo_head_s;
    logic                 pop_s;
    logic [2:0]           occ_s;
    logic                 room_s;

    assign pop_s = fifo_valid_s & m_if.m_ready;

    // Slots committed after this cycle: stored bytes plus the read whose data
    // lands this cycle, minus the byte leaving now. Below 2 means a new read
    // still fits once its data returns.
    assign occ_s  = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign room_s = (occ_s < 3'd2);

    // Next-state, read issue and overrun detection.
    always_comb begin
        state_d         = state_q;
        r_addr_d        = r_addr_q;
        issued_d        = issued_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        overrun_d       = overrun_q;
        case (state_q)
            RD_IDLE: begin
                if (good_to_go) begin
                    state_d  = RD_STREAM;
                    r_addr_d = '0;
                    issued_d = '0;
                end else begin
                    state_d = RD_IDLE;
                end
            end
            RD_STREAM: begin
                if (good_to_go) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (room_s) begin
                    inflight_d      = 1'b1;
                    inflight_last_d = (r_addr_q == LAST_ADDR);
                    issued_d        = issued_q + ISSUE_W'(1);
                    // The pointer parks on the final word rather than wrapping.
                    if (r_addr_q != LAST_ADDR) begin
                        r_addr_d = r_addr_q + ADDR_W'(1);
                    end else begin
                        r_addr_d = r_addr_q;
                    end
                    if (issued_q == LAST_ISSUE) begin
                        state_d = RD_DRAIN;
                    end else begin
                        state_d = RD_STREAM;
                    end
                end else begin
                    state_d = RD_STREAM;
                end
            end
            RD_DRAIN: begin
                if (good_to_go) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                // Leave as the final byte is accepted so read_done rises the
                // very next cycle.
                if (!inflight_q &&
                    ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && pop_s))) begin
                    state_d = RD_IDLE;
                end else begin
                    state_d = RD_DRAIN;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
        read_done_d = (state_d == RD_IDLE);
    end

    // Controller registers; reset also discards any in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= RD_IDLE;
            r_addr_q        <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            read_done_q     <= 1'b1;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            r_addr_q        <= r_addr_d;
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            read_done_q     <= read_done_d;
            overrun_q       <= overrun_d;
        end
    end

    pingpong_skid2 #(.W(DATA_W + 1)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .push_i  (inflight_q),
        .din_i   ({inflight_last_q, r_q}),
        .pop_i   (pop_s),
        .dout_o  (fifo_head_s),
        .valid_o (fifo_valid_s),
        .count_o (fifo_count_s)
    );

    assign r_addr      = r_addr_q;
    assign read_done   = read_done_q;
    assign overrun     = overrun_q;
    assign m_if.m_data  = fifo_head_s[DATA_W-1:0];
    assign m_if.m_valid = fifo_valid_s;
    // The head keeps its stale tag after draining, so qualify it with valid.
    assign m_if.m_last  = fifo_head_s[DATA_W] & fifo_valid_s;

endmodule

// File: tb/tb_pingpong_reader.sv
// Bench for pingpong_reader: RAM model returns q = addr[7:0]; a frame-level
// model (active flag + index of the next expected byte) is checked every cycle.
module tb_pingpong_reader;
    import pingpong_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              good_to_go = 1'b0;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_q = '0;
    logic              read_done;
    logic              overrun;

    pingpong_reader_if sif ();

    pingpong_reader dut (
        .clk        (clk),
        .reset      (reset),
        .good_to_go (good_to_go),
        .r_addr     (r_addr),
        .r_q        (r_q),
        .read_done  (read_done),
        .overrun    (overrun),
        .m_if       (sif)
    );

    always #5 clk = ~clk;

    // RAM model with one cycle of read latency.
    always @(posedge clk) r_q <= r_addr[7:0];

    // Frame model: which byte must come next, and whether a frame is open.
    bit active = 1'b0;
    bit ovr_exp = 1'b0;
    int exp_idx = 0;
    int hs_cnt = 0;
    int last_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            ovr_exp <= 1'b0;
            exp_idx <= 0;
        end else begin
            if (good_to_go) begin
                if (!active) begin
                    active  <= 1'b1;
                    exp_idx <= 0;
                end else begin
                    ovr_exp <= 1'b1;
                end
            end
            if (active && sif.m_valid && sif.m_ready) begin
                exp_idx <= exp_idx + 1;
                if (exp_idx == DEPTH - 1) active <= 1'b0;
            end
        end
        if (!reset && sif.m_valid && sif.m_ready) begin
            hs_cnt <= hs_cnt + 1;
            if (sif.m_last) last_cnt <= last_cnt + 1;
        end
    end

    // Per-cycle compare against the model.
    int m_vec = 0;
    int m_err = 0;
    bit stall_prev = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    function automatic void mchk(string nm, logic [31:0] act, logic [31:0] exp);
        m_vec++;
        if (act !== exp) begin
            m_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            mchk("read_done", 32'(read_done), 32'(!active));
            mchk("overrun", 32'(overrun), 32'(ovr_exp));
            if (sif.m_valid) begin
                mchk("valid_in_frame", 32'(active), 32'd1);
                mchk("m_data", 32'(sif.m_data), 32'(exp_idx[7:0]));
                mchk("m_last", 32'(sif.m_last), 32'(exp_idx == DEPTH - 1));
            end
            if (active) begin
                mchk("reads_ahead_le2", 32'(int'(r_addr) <= exp_idx + 2), 32'd1);
            end
            if (stall_prev) begin
                mchk("stall_valid", 32'(sif.m_valid), 32'd1);
                mchk("stall_data", 32'(sif.m_data), 32'(prev_data));
                mchk("stall_last", 32'(sif.m_last), 32'(prev_last));
            end
        end
        stall_prev = !reset && sif.m_valid && !sif.m_ready;
        prev_data  = sif.m_data;
        prev_last  = sif.m_last;
    end

    // Directed stimulus and literal checks.
    int d_vec = 0;
    int d_err = 0;
    int mode = 0;   // 0: ready high, 1: random ready, 2: ready low

    function automatic void dchk(string nm, logic [31:0] act, logic [31:0] exp);
        d_vec++;
        if (act !== exp) begin
            d_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        case (mode)
            0:       sif.m_ready = 1'b1;
            1:       sif.m_ready = 1'($urandom_range(0, 1));
            default: sif.m_ready = 1'b0;
        endcase
    endtask

    task automatic pulse();
        good_to_go = 1'b1;
        step();
        good_to_go = 1'b0;
    endtask

    task automatic wait_idx(int k);
        int n = 0;
        while (exp_idx < k && n < 5000) begin
            step();
            n++;
        end
        dchk("wait_idx_timeout", 32'(exp_idx >= k), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (active && n < 8000) begin
            step();
            n++;
        end
        dchk("wait_idle_timeout", 32'(active), 32'd0);
    endtask

    initial begin
        int h0;
        int l0;
        int k;
        bit sent2;
        sif.m_ready = 1'b0;

        // Reset values.
        repeat (3) step();
        dchk("rst_read_done", 32'(read_done), 32'd1);
        dchk("rst_m_valid", 32'(sif.m_valid), 32'd0);
        dchk("rst_m_last", 32'(sif.m_last), 32'd0);
        dchk("rst_m_data", 32'(sif.m_data), 32'd0);
        dchk("rst_r_addr", 32'(r_addr), 32'd0);
        dchk("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        step();

        // Frame with ready held high: latency and last-byte position.
        h0 = hs_cnt; l0 = last_cnt;
        pulse();
        dchk("t1_r_addr0", 32'(r_addr), 32'd0);
        dchk("t1_busy", 32'(read_done), 32'd0);
        k = 1;
        while (!sif.m_valid && k < 10) begin
            step();
            k++;
        end
        dchk("t1_first_valid_lat", 32'(k), 32'd3);
        dchk("t1_first_byte", 32'(sif.m_data), 32'h00);
        k = 0;
        while (!sif.m_last && k < 600) begin
            step();
            k++;
        end
        dchk("t1_last_offset", 32'(k), 32'd511);
        dchk("t1_last_data", 32'(sif.m_data), 32'hFF);
        dchk("t1_done_low_at_last", 32'(read_done), 32'd0);
        step();
        dchk("t1_done_after_last", 32'(read_done), 32'd1);
        dchk("t1_bytes", 32'(hs_cnt - h0), 32'd512);
        dchk("t1_lasts", 32'(last_cnt - l0), 32'd1);

        // Random backpressure.
        mode = 1;
        h0 = hs_cnt; l0 = last_cnt;
        pulse();
        wait_idle();
        dchk("t2_bytes", 32'(hs_cnt - h0), 32'd512);
        dchk("t2_lasts", 32'(last_cnt - l0), 32'd1);
        mode = 0;
        step();

        // Long stall after the first byte: pointer freezes two reads ahead.
        h0 = hs_cnt;
        pulse();
        wait_idx(1);
        sif.m_ready = 1'b0;
        mode = 2;
        dchk("t3_r_addr_stall", 32'(r_addr), 32'd3);
        for (int i = 0; i < 20; i++) begin
            step();
            dchk("t3_r_addr_frozen", 32'(r_addr), 32'd3);
        end
        dchk("t3_held_byte", 32'(sif.m_data), 32'h01);
        mode = 0;
        wait_idle();
        dchk("t3_bytes", 32'(hs_cnt - h0), 32'd512);

        // Second good_to_go mid-frame.
        step();
        h0 = hs_cnt;
        pulse();
        wait_idx(100);
        pulse();
        dchk("t4_overrun_set", 32'(overrun), 32'd1);
        wait_idle();
        dchk("t4_bytes", 32'(hs_cnt - h0), 32'd512);
        dchk("t4_overrun_sticky", 32'(overrun), 32'd1);

        // Reset at byte 300, with a coincident good_to_go that must be ignored.
        step();
        pulse();
        wait_idx(300);
        reset = 1'b1;
        good_to_go = 1'b1;
        step();
        reset = 1'b0;
        good_to_go = 1'b0;
        dchk("t5_valid_after_rst", 32'(sif.m_valid), 32'd0);
        dchk("t5_done_after_rst", 32'(read_done), 32'd1);
        dchk("t5_overrun_cleared", 32'(overrun), 32'd0);
        repeat (3) step();
        dchk("t5_gtg_ignored", 32'(read_done), 32'd1);
        h0 = hs_cnt;
        pulse();
        wait_idle();
        dchk("t5_bytes", 32'(hs_cnt - h0), 32'd512);

        // Back-to-back frames, second pulse the cycle read_done rises.
        step();
        h0 = hs_cnt; l0 = last_cnt;
        good_to_go = 1'b1;
        sent2 = 1'b0;
        for (int i = 0; i < 3000 && !(sent2 && !active && !good_to_go); i++) begin
            step();
            good_to_go = 1'b0;
            if (!active && !sent2) begin
                dchk("t6_done_rises", 32'(read_done), 32'd1);
                good_to_go = 1'b1;
                sent2 = 1'b1;
            end
        end
        dchk("t6_bytes", 32'(hs_cnt - h0), 32'd1024);
        dchk("t6_lasts", 32'(last_cnt - l0), 32'd2);
        dchk("t6_overrun", 32'(overrun), 32'd0);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", m_vec + d_vec, m_err + d_err);
        $finish;
    end

endmodule

// File: doc/pingpong_reader.md
Name: pingpong_reader

Overview:
- Read-side controller for the 8x512 ping-pong sample buffer.
- Waits for the buffer's good_to_go pulse, then sweeps read addresses 0..DEPTH-1 through the one-cycle-latency RAM read port.
- Emits the bytes as a valid/ready stream, marking the last byte of each frame.
- Holds read_done high between frames so the buffer may swap banks; feeds the downstream beamforming/transmit path.

Parameters:
- DATA_W, 8, width of each buffer word and stream byte.
- ADDR_W, 9, buffer address width.
- DEPTH, 512, words per frame; must equal 2**ADDR_W or be smaller.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- good_to_go  input  1  one-cycle pulse from the buffer: a fresh bank is mapped to the read port.
- r_addr  output  ADDR_W  buffer read address.
- r_q  input  DATA_W  buffer read data; valid the cycle after r_addr is presented.
- read_done  output  1  high while no further reads are needed (idle).
- m_data  output  DATA_W  stream data.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accepts when m_valid & m_ready.
- m_last  output  1  high with m_valid on byte DEPTH-1.
- overrun  output  1  sticky: good_to_go arrived while a frame was in progress.

Behaviour:
- Reset values:
  - read_done=1, m_valid=0, m_last=0, m_data=0, r_addr=0, overrun=0.
  - State IDLE; read pointer, issue count and in-flight flag cleared; output FIFO emptied.
- A reset mid-frame abandons the frame and returns to IDLE immediately; no partial bytes are emitted afterwards.
- State machine:
  - IDLE: read_done=1. good_to_go -> STREAM; rd_ptr=0.
  - STREAM: read_done=0. When all DEPTH reads are issued -> DRAIN.
  - DRAIN: read_done=0. When the FIFO is empty and nothing is in flight -> IDLE.
- Issue rule:
  - In STREAM, r_addr=rd_ptr.
  - A read is issued in a cycle when fifo_count + inflight < 2, counting a byte popped this cycle as freed space.
  - On issue, rd_ptr increments and inflight is set for the next cycle, when r_q is pushed into the FIFO.
  - When not issuing, r_addr holds its last value.
  - rd_ptr never wraps within a frame; it stops at DEPTH-1.
- Output FIFO:
  - 2 entries; m_data and m_valid come from the head entry, registered.
  - Simultaneous push and pop is supported.
  - m_last is tagged on the entry whose address is DEPTH-1.
- Latency with m_ready held high:
  - good_to_go at cycle N; r_addr=0 at N+1; r_q(0) at N+2; m_valid with byte 0 at N+3.
  - Then one byte per cycle; m_last at N+2+DEPTH.
  - read_done rises the cycle after the last handshake.
- Backpressure:
  - m_data and m_last are stable while m_valid & !m_ready.
  - No byte is dropped or duplicated.
  - Issuing stalls when the FIFO plus the in-flight read reaches 2.
- Boundary cases:
  - good_to_go in STREAM/DRAIN: ignored for control; overrun set (sticky until reset).
  - good_to_go in the same cycle read_done is high (IDLE): accepted; a new frame starts.
  - A good_to_go pulse coincident with reset is ignored.
  - m_ready high while m_valid=0 has no effect.

Decomposition:
- Package pingpong_pkg:
  - localparams DATA_W, ADDR_W, DEPTH.
  - Enum rd_state_t {RD_IDLE, RD_STREAM, RD_DRAIN}.
  - Also reused by the writer-side block.
- Sub-module pingpong_skid2: 2-entry registered FIFO carrying {last, data}, with push/pop/count.

Test Plan:
- Reset, then one good_to_go pulse with m_ready=1 and the RAM model holding q=addr[7:0]:
  - m_valid first at pulse+3 with data 0x00.
  - 512 consecutive bytes 0x00..0xFF twice.
  - m_last only on byte 511.
  - read_done rises 1 cycle after the final handshake.
- Same frame with m_ready toggled by a pseudo-random 50% pattern:
  - Received sequence is identical, with no gaps/duplicates.
  - Data stays stable during stalls.
  - FIFO never exceeds 2 entries.
- m_ready held low for 20 cycles after the first byte:
  - At most 2 reads issued beyond the accepted bytes.
  - r_addr is frozen.
  - Stream resumes with byte 1.
- Second good_to_go at byte 100 of a frame:
  - overrun=1 and stays 1.
  - The frame still completes with 512 bytes; no restart.
- reset asserted at byte 300:
  - Next cycle m_valid=0, read_done=1.
  - A subsequent good_to_go yields a full frame starting at byte 0.
- Back-to-back frames, with good_to_go pulsed the cycle read_done rises:
  - 1024 bytes with exactly two m_last.
  - overrun stays 0.
